// File: rtl/pcm_stream_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcm_stream_if : host-write, DAC-fetch and sample-output bundle of pcm_stream
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pcm_stream_if #(
    parameter int AW = 10
);
    logic          play_en;
    logic          flush;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          fifo_full;
    logic [AW:0]   fifo_level;
    logic          underrun;
    logic          underrun_clr;
    logic          next_byte;
    logic          next_sample;
    logic [15:0]   snd_l;
    logic [15:0]   snd_r;
    logic          snd_on;

    modport master (
        output play_en, flush, wr_en, wr_data, underrun_clr, next_byte, next_sample,
        input  fifo_full, fifo_level, underrun, snd_l, snd_r, snd_on
    );

    modport slave (
        input  play_en, flush, wr_en, wr_data, underrun_clr, next_byte, next_sample,
        output fifo_full, fifo_level, underrun, snd_l, snd_r, snd_on
    );
endinterface
`default_nettype wire

// File: rtl/pcm_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pcm_stream : byte FIFO feeding 16-bit stereo frames to the audio stage
// Revision: 1.0
// ---------------------------------------------------------------------------
module pcm_stream #(
    parameter int AW          = 10,
    parameter int START_LEVEL = 512
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pcm_stream_if.slave   bus
);
    localparam int              DEPTH      = 2 ** AW;
    localparam logic [AW:0]     C_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_START    = (AW+1)'(START_LEVEL);
    localparam logic [AW:0]     C_LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   C_PTR_ONE  = (AW)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_full;
    logic            r_underrun;
    logic            r_frame_ur;
    logic [1:0]      r_idx;
    logic [7:0]      r_stage [4];
    logic [15:0]     r_snd_l;
    logic [15:0]     r_snd_r;

    logic            w_play;
    logic            w_fetch;
    logic            w_pop;
    logic            w_starve;
    logic            w_wr;
    logic [1:0]      w_slot;
    logic [7:0]      w_byte;
    logic [AW:0]     w_level_next;

    assign w_play   = (r_state == ST_PLAY);
    assign w_fetch  = w_play & bus.next_byte;
    assign w_pop    = w_fetch & (r_level != '0);
    assign w_starve = w_fetch & (r_level == '0);
    assign w_wr     = bus.wr_en & ~r_full;
    // A fetch coinciding with the frame strobe belongs to the new frame.
    assign w_slot   = bus.next_sample ? 2'd0 : r_idx;
    assign w_byte   = w_pop ? r_mem[r_rd_ptr] : 8'h00;

    always_comb begin
        w_level_next = r_level;
        if (w_wr && !w_pop) begin
            w_level_next = r_level + C_LVL_ONE;
        end else if (!w_wr && w_pop) begin
            w_level_next = r_level - C_LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = bus.play_en ? ST_FILL : ST_IDLE;
        end else if (bus.next_sample) begin
            case (r_state)
                ST_IDLE: if (bus.play_en) w_state_next = ST_FILL;
                ST_FILL: begin
                    if (!bus.play_en) begin
                        w_state_next = ST_IDLE;
                    end else if (r_level >= C_START) begin
                        w_state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!bus.play_en) begin
                        w_state_next = ST_IDLE;
                    end else if (r_frame_ur) begin
                        w_state_next = ST_FILL;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
            r_frame_ur <= 1'b0;
            r_idx      <= 2'd0;
            r_snd_l    <= '0;
            r_snd_r    <= '0;
            for (int i = 0; i < 4; i++) r_stage[i] <= '0;
        end else if (bus.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_frame_ur <= 1'b0;
            r_idx      <= 2'd0;
            for (int i = 0; i < 4; i++) r_stage[i] <= '0;
            if (bus.underrun_clr) r_underrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            r_level <= w_level_next;
            r_full  <= (w_level_next == C_DEPTH);

            if (bus.underrun_clr) begin
                r_underrun <= 1'b0;
            end else if (w_starve) begin
                r_underrun <= 1'b1;
            end

            if (bus.next_sample) begin
                r_frame_ur <= w_starve;
            end else if (w_starve) begin
                r_frame_ur <= 1'b1;
            end

            if (bus.next_sample && w_play) begin
                r_snd_l <= {r_stage[1], r_stage[0]};
                r_snd_r <= {r_stage[3], r_stage[2]};
            end

            if (w_fetch) begin
                r_stage[w_slot] <= w_byte;
                r_idx           <= w_slot + 2'd1;
            end else if (bus.next_sample) begin
                r_idx <= 2'd0;
            end
        end
    end

    assign bus.fifo_full  = r_full;
    assign bus.fifo_level = r_level;
    assign bus.underrun   = r_underrun;
    assign bus.snd_l      = r_snd_l;
    assign bus.snd_r      = r_snd_r;
    assign bus.snd_on     = w_play;
endmodule
`default_nettype wire

// File: tb/tb_pcm_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pcm_stream : directed vectors plus random traffic against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pcm_stream;
    localparam int AW          = 10;
    localparam int START_LEVEL = 4;
    localparam int DEPTH       = 1 << AW;
    localparam int M_IDLE      = 0;
    localparam int M_FILL      = 1;
    localparam int M_PLAY      = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcm_stream_if #(.AW(AW)) bus ();

    pcm_stream #(.AW(AW), .START_LEVEL(START_LEVEL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: stream mode, byte queue, frame under assembly.
    logic [7:0]  q[$];
    int          m_mode;
    logic [7:0]  m_fb [4];
    int          m_idx;
    bit          m_fur;
    bit          m_ur;
    logic [15:0] m_l;
    logic [15:0] m_r;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        pe;
        logic        we;
        logic [7:0]  wd;
        logic        nb;
        logic        ns;
        int          e_lvl;
        logic [15:0] e_l;
        logic [15:0] e_r;
        logic        e_on;
    } vec_t;

    vec_t       tbl [20];
    logic [7:0] seq8 [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input bit rn, pe, fl, we, input logic [7:0] wd,
                              input bit nb, ns, clr);
        int         sz;
        bit         playing;
        bit         acc;
        bit         starve;
        int         k;
        logic [7:0] b;
        sz      = q.size();
        playing = (m_mode == M_PLAY);
        if (!rn) begin
            q.delete();
            m_mode = M_IDLE;
            m_fb   = '{default: 8'h00};
            m_idx  = 0;
            m_fur  = 0;
            m_ur   = 0;
            m_l    = '0;
            m_r    = '0;
        end else if (fl) begin
            q.delete();
            m_fb   = '{default: 8'h00};
            m_idx  = 0;
            m_fur  = 0;
            m_mode = pe ? M_FILL : M_IDLE;
            if (clr) m_ur = 0;
        end else begin
            acc    = we && (sz < DEPTH);
            starve = playing && nb && (sz == 0);
            b      = 8'h00;
            if (playing && nb && sz > 0) b = q.pop_front();
            if (acc) q.push_back(wd);
            if (ns) begin
                if (playing) begin
                    m_l = {m_fb[1], m_fb[0]};
                    m_r = {m_fb[3], m_fb[2]};
                end
                if (!pe) m_mode = M_IDLE;
                else if (m_mode == M_IDLE) m_mode = M_FILL;
                else if (m_mode == M_FILL && sz >= START_LEVEL) m_mode = M_PLAY;
                else if (m_mode == M_PLAY && m_fur) m_mode = M_FILL;
            end
            if (playing && nb) begin
                k       = ns ? 0 : m_idx;
                m_fb[k] = b;
                m_idx   = (k + 1) % 4;
            end else if (ns) begin
                m_idx = 0;
            end
            if (clr) m_ur = 0;
            else if (starve) m_ur = 1;
            m_fur = ns ? starve : (m_fur | starve);
        end
    endtask

    task automatic cyc(input bit rn, pe, fl, we, input logic [7:0] wd,
                       input bit nb, ns, clr);
        rst_n            = rn;
        bus.play_en      = pe;
        bus.flush        = fl;
        bus.wr_en        = we;
        bus.wr_data      = wd;
        bus.next_byte    = nb;
        bus.next_sample  = ns;
        bus.underrun_clr = clr;
        @(posedge clk);
        #1;
        model_step(rn, pe, fl, we, wd, nb, ns, clr);
        chk("model_level",  32'(bus.fifo_level), 32'(q.size()));
        chk("model_full",   32'(bus.fifo_full),  32'(q.size() == DEPTH));
        chk("model_underrun", 32'(bus.underrun), 32'(m_ur));
        chk("model_snd_l",  32'(bus.snd_l),      32'(m_l));
        chk("model_snd_r",  32'(bus.snd_r),      32'(m_r));
        chk("model_snd_on", 32'(bus.snd_on),     32'(m_mode == M_PLAY));
    endtask

    task automatic wr(input bit pe, input logic [7:0] b);
        cyc(1, pe, 0, 1, b, 0, 0, 0);
    endtask
    task automatic nbt(input bit pe);
        cyc(1, pe, 0, 0, 8'h00, 1, 0, 0);
    endtask
    task automatic nst(input bit pe);
        cyc(1, pe, 0, 0, 8'h00, 0, 1, 0);
    endtask

    initial begin
        bit  pe_r;
        bit  nb_r;
        bit  ns_r;
        int  cnt;
        int  wprob;

        seq8 = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hCD, 8'hAB, 8'h01, 8'hEF};
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b1, seq8[i], 1'b0, 1'b0, i + 1, 16'h0, 16'h0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8, 16'h0, 16'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8, 16'h0, 16'h0, 1'b1};
        for (int i = 0; i < 4; i++)
            tbl[10+i] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 7 - i, 16'h0, 16'h0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4, 16'h1234, 16'h5678, 1'b1};
        for (int i = 0; i < 4; i++)
            tbl[15+i] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3 - i, 16'h1234, 16'h5678, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0, 16'hABCD, 16'hEF01, 1'b1};

        // Reset state
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        chk("rst_full",  32'(bus.fifo_full),  0);
        chk("rst_on",    32'(bus.snd_on),     0);
        chk("rst_snd",   {bus.snd_l, bus.snd_r}, 0);

        // Frame assembly and byte order
        foreach (tbl[i]) begin
            cyc(1, tbl[i].pe, 0, tbl[i].we, tbl[i].wd, tbl[i].nb, tbl[i].ns, 0);
            chk($sformatf("vec%0d_level", i), 32'(bus.fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d_snd_l", i), 32'(bus.snd_l), 32'(tbl[i].e_l));
            chk($sformatf("vec%0d_snd_r", i), 32'(bus.snd_r), 32'(tbl[i].e_r));
            chk($sformatf("vec%0d_snd_on", i), 32'(bus.snd_on), 32'(tbl[i].e_on));
        end

        // Underrun mid-frame
        wr(1, 8'hAA);
        wr(1, 8'hBB);
        nbt(1);
        nbt(1);
        chk("ur_before", 32'(bus.underrun), 0);
        nbt(1);
        chk("ur_after_3rd", 32'(bus.underrun), 1);
        nbt(1);
        nst(1);
        chk("ur_snd_l", 32'(bus.snd_l), 32'h0000BBAA);
        chk("ur_snd_r", 32'(bus.snd_r), 32'h00000000);
        chk("ur_snd_on", 32'(bus.snd_on), 0);
        cyc(1, 1, 0, 0, 8'h00, 0, 0, 1);
        chk("ur_clr", 32'(bus.underrun), 0);

        // play_en drop inside a frame
        for (int i = 0; i < 8; i++) wr(1, 8'(8'h11 * (i + 1)));
        nst(1);
        chk("pe_play", 32'(bus.snd_on), 1);
        nbt(1);
        nbt(0);
        nbt(0);
        nbt(0);
        nst(0);
        chk("pe_snd_l", 32'(bus.snd_l), 32'h2211);
        chk("pe_snd_r", 32'(bus.snd_r), 32'h4433);
        chk("pe_idle", 32'(bus.snd_on), 0);
        chk("pe_level", 32'(bus.fifo_level), 4);
        repeat (4) nbt(0);
        nst(0);
        chk("pe_hold_level", 32'(bus.fifo_level), 4);
        chk("pe_hold_snd", {bus.snd_l, bus.snd_r}, 32'h22114433);

        // Flush colliding with write and fetch
        nst(1);
        nst(1);
        chk("fl_play", 32'(bus.snd_on), 1);
        nbt(1);
        cyc(1, 1, 1, 1, 8'h99, 1, 0, 0);
        chk("fl_level", 32'(bus.fifo_level), 0);
        chk("fl_on", 32'(bus.snd_on), 0);
        chk("fl_snd", {bus.snd_l, bus.snd_r}, 32'h22114433);
        wr(1, 8'hA1); wr(1, 8'hB2); wr(1, 8'hC3); wr(1, 8'hD4);
        nst(1);
        repeat (4) nbt(1);
        nst(1);
        chk("fl_next_frame", {bus.snd_l, bus.snd_r}, 32'hB2A1D4C3);

        // Full FIFO
        cyc(1, 0, 1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) wr(0, 8'(i));
        chk("full_level", 32'(bus.fifo_level), DEPTH);
        chk("full_flag", 32'(bus.fifo_full), 1);
        wr(0, 8'h5A);
        chk("full_drop_level", 32'(bus.fifo_level), DEPTH);
        nst(1);
        nst(1);
        cyc(1, 1, 0, 1, 8'h5A, 1, 0, 0);
        chk("full_pop_wr_level", 32'(bus.fifo_level), DEPTH - 1);
        chk("full_pop_wr_flag", 32'(bus.fifo_full), 0);
        repeat (3) nbt(1);
        nst(1);
        chk("full_first_frame", {bus.snd_l, bus.snd_r}, 32'h01000302);

        // Reset mid-frame
        nbt(1);
        nbt(1);
        cyc(0, 1, 0, 0, 8'h00, 0, 0, 0);
        chk("mr_level", 32'(bus.fifo_level), 0);
        chk("mr_outputs", {bus.snd_l, bus.snd_r}, 0);
        chk("mr_on", 32'(bus.snd_on), 0);
        wr(1, 8'h01); wr(1, 8'h02); wr(1, 8'h03);
        nst(1);
        nst(1);
        chk("mr_wait_fill", 32'(bus.snd_on), 0);
        wr(1, 8'h04);
        nst(1);
        chk("mr_restart", 32'(bus.snd_on), 1);

        // Random traffic against the model
        pe_r  = 1;
        cnt   = 0;
        wprob = 50;
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) wprob = $urandom_range(15, 90);
            if ($urandom_range(0, 149) == 0) pe_r = ~pe_r;
            nb_r = ($urandom_range(0, 2) == 0);
            ns_r = (cnt >= 4 && $urandom_range(0, 1) == 0) || ($urandom_range(0, 149) == 0);
            cyc(($urandom_range(0, 1499) != 0), pe_r, ($urandom_range(0, 399) == 0),
                ($urandom_range(0, 99) < wprob), 8'($urandom), nb_r, ns_r,
                ($urandom_range(0, 59) == 0));
            if (ns_r) cnt = nb_r ? 1 : 0;
            else if (nb_r) cnt++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
